// File: rtl/cam_fifo.sv
// cam_fifo: first-word-fall-through FIFO with per-slot valid bits, masked parallel tag search,
// oldest-hit age reporting, kill-by-match and write-while-full when paired with a read.
module cam_fifo #(
  parameter int W_DATA = 32,
  parameter int W_TAG = W_DATA,
  parameter int P_TAGLSB = 0,
  parameter int C_DEPTH = 8,
  parameter int C_AFULL = C_DEPTH - 1,
  localparam int LW_ADDR = $clog2(C_DEPTH)
) (
  input  logic               sClk_i,
  input  logic               snRst_i,
  input  logic               Write_i,
  input  logic [W_DATA-1:0]  WriteData_i,
  input  logic               Read_i,
  output logic [W_DATA-1:0]  ReadData_oc,
  output logic               ReadValid_oc,
  output logic               Empty_oc,
  output logic               Full_oc,
  output logic               AlmostFull_oc,
  output logic [LW_ADDR:0]   Level_oc,
  input  logic               CompareEn_i,
  input  logic [W_TAG-1:0]   CompareTag_i,
  input  logic [W_TAG-1:0]   CompareMask_i,
  input  logic               Kill_i,
  output logic [C_DEPTH-1:0] Hit_oc,
  output logic               AnyHit_oc,
  output logic [LW_ADDR-1:0] HitAge_oc
);
  localparam logic [LW_ADDR:0] LP_DEPTH = C_DEPTH[LW_ADDR:0];
  logic [W_DATA-1:0]  r_data [C_DEPTH];
  logic [C_DEPTH-1:0] r_occ, r_vld, w_occ_nxt, w_vld_nxt, w_hit;
  logic [LW_ADDR-1:0] r_wptr, r_rptr, w_age;
  logic [LW_ADDR:0]   r_cnt;
  logic               w_empty, w_full, w_rd, w_wr;
  assign w_empty = r_cnt == '0;
  assign w_full  = r_cnt == LP_DEPTH;
  assign w_rd    = Read_i & ~w_empty;
  assign w_wr    = Write_i & (~w_full | w_rd);
  for (genvar i = 0; i < C_DEPTH; i++) begin : g_cmp
    assign w_hit[i] = CompareEn_i & r_occ[i] & r_vld[i] &
                      ~|((r_data[i][P_TAGLSB +: W_TAG] ^ CompareTag_i) & CompareMask_i);
  end
  // scan from youngest to oldest so the oldest hit is the last one to win
  always_comb begin
    w_age = '0;
    for (int k = C_DEPTH - 1; k >= 0; k--)
      if (w_hit[r_rptr + LW_ADDR'(k)]) w_age = LW_ADDR'(k);
  end
  // kill and pop clear first; a write into the slot being popped while full then wins
  always_comb begin
    w_occ_nxt = r_occ;
    w_vld_nxt = r_vld & ~(Kill_i ? w_hit : '0);
    if (w_rd) begin
      w_occ_nxt[r_rptr] = 1'b0;
      w_vld_nxt[r_rptr] = 1'b0;
    end
    if (w_wr) begin
      w_occ_nxt[r_wptr] = 1'b1;
      w_vld_nxt[r_wptr] = 1'b1;
    end
  end
  always_ff @(posedge sClk_i or negedge snRst_i) begin
    if (!snRst_i) begin
      for (int i = 0; i < C_DEPTH; i++) r_data[i] <= '0;
      r_occ  <= '0;
      r_vld  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      r_vld <= w_vld_nxt;
      if (w_wr) begin
        r_data[r_wptr] <= WriteData_i;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr & ~w_rd) r_cnt <= r_cnt + 1'b1;
      else if (w_rd & ~w_wr) r_cnt <= r_cnt - 1'b1;
    end
  end
  assign ReadData_oc   = w_empty ? '0 : r_data[r_rptr];
  assign ReadValid_oc  = r_occ[r_rptr] & r_vld[r_rptr];
  assign Empty_oc      = w_empty;
  assign Full_oc       = w_full;
  assign AlmostFull_oc = int'(r_cnt) >= C_AFULL;
  assign Level_oc      = r_cnt;
  assign Hit_oc        = w_hit;
  assign AnyHit_oc     = |w_hit;
  assign HitAge_oc     = w_age;
endmodule

// File: doc/cam_fifo.md
# cam_fifo

First-word-fall-through FIFO whose stored entries can also be searched in parallel against a tag, for the cache miss and write-buffer paths. Each slot carries a valid bit, so entries do not need clearing on read. It adds four features over a plain compare FIFO: a masked tag compare, oldest-hit reporting, selective kill (invalidate-by-match), and write-while-full when a read happens in the same cycle.

## Interface
Parameters:
- W_DATA, 32, stored word width
- W_TAG, W_DATA, compared field width
- P_TAGLSB, 0, LSB of the tag field inside a word; the field is bits [P_TAGLSB+W_TAG-1 : P_TAGLSB]
- C_DEPTH, 8, slot count; power of two, ≥2
- C_AFULL, C_DEPTH-1, level at or above which AlmostFull_oc is asserted
- LW_ADDR, $clog2(C_DEPTH), derived; not overridable

Ports:
- sClk_i  in  1  clock; all state on the rising edge
- snRst_i  in  1  asynchronous active-low reset
- Write_i  in  1  push request
- WriteData_i  in  W_DATA  push data
- Read_i  in  1  pop request
- ReadData_oc  out  W_DATA  head word; 0 when empty
- ReadValid_oc  out  1  head occupied and not killed
- Empty_oc  out  1  no slots occupied
- Full_oc  out  1  C_DEPTH slots occupied
- AlmostFull_oc  out  1  Level_oc ≥ C_AFULL
- Level_oc  out  LW_ADDR+1  occupied slot count, including killed slots
- CompareEn_i  in  1  enables the compare outputs
- CompareTag_i  in  W_TAG  search tag
- CompareMask_i  in  W_TAG  1 = bit participates in the compare
- Kill_i  in  1  invalidate every slot hit this cycle
- Hit_oc  out  C_DEPTH  per physical slot: hit
- AnyHit_oc  out  1  OR of Hit_oc
- HitAge_oc  out  LW_ADDR  age of the oldest hit; 0 = head; 0 when there is no hit

## Operation
- State:
  - data array, C_DEPTH×W_DATA
  - Occ[C_DEPTH], slot occupied
  - Vld[C_DEPTH], slot valid
  - WPtr, RPtr, LW_ADDR bits
  - Cnt, LW_ADDR+1 bits
- Pointers increment modulo C_DEPTH and wrap from C_DEPTH-1 to 0.
- Derived flags: Full = (Cnt == C_DEPTH); Empty = (Cnt == 0).
- Hit, per slot i:
  - Hit[i] = CompareEn_i & Occ[i] & Vld[i] & ((data[i][tag] ^ CompareTag_i) & CompareMask_i) == 0.
  - Killed slots never hit.
  - All-zero mask: every valid slot hits.
- Oldest-hit priority:
  - Age of slot i = (i - RPtr) mod C_DEPTH.
  - HitAge_oc is the minimum age among hit slots.
- Accept rules:
  - ReadEn = Read_i & ~Empty.
  - WriteEn = Write_i & (~Full | ReadEn); a write while full is accepted only together with a read.
- Write: data[WPtr] <= WriteData_i; Occ and Vld of that slot set; WPtr advances.
- Read: Occ[RPtr] and Vld[RPtr] cleared; RPtr advances. Data is not cleared.
- Cnt update: +1 on write only, -1 on read only, unchanged when both or neither happen.
- Kill:
  - For every i with Hit[i], Vld[i] is cleared; Occ is untouched.
  - A killed slot stays in order and is popped normally with ReadValid_oc=0; the consumer discards it.
- Same-cycle interactions:
  - Kill and write: the compare sees pre-write contents, so the new entry is valid.
  - Kill and read of the head: the slot is freed.
  - Write into the slot being read while full: the write wins, and Occ/Vld end up set.
- Read and write on empty: the read is ignored and the write is accepted.
- Kill_i with CompareEn_i=0 has no effect.

## Timing
- ReadData_oc, ReadValid_oc, Hit_oc, AnyHit_oc and HitAge_oc are combinational from registered state and the current compare inputs. There is no pipeline.
- A pushed word is visible at the head and searchable the cycle after its write edge; FWFT latency is 1.
- Empty_oc, Full_oc, AlmostFull_oc and Level_oc are updated at the edge of the accepted operation.
- Kill takes effect at the clock edge; compares see it from the next cycle onward.
- Reset, asserted at any time and also mid-burst:
  - Immediately: Cnt=0, WPtr=RPtr=0, Occ=Vld=0, data=0.
  - Outputs: Empty_oc=1; Full_oc=0; Level_oc=0; ReadValid_oc=0; ReadData_oc=0; Hit_oc=0; AnyHit_oc=0; HitAge_oc=0; AlmostFull_oc=(C_AFULL==0).
- Release of reset is synchronous to sClk_i by the system.

## Test plan
Defaults C_DEPTH=8, W_DATA=32, full mask unless stated.
- Fill and drain: write 1..8 → Full_oc=1, Level_oc=8, AlmostFull_oc at Level 7. A 9th write alone is dropped. Eight reads return 1..8 in order; then Empty_oc=1 and ReadData_oc=0.
- Wrap and pass-through:
  - Write 6, read 6, write 8 → Full_oc=1.
  - Write 0xAA together with a read → accepted, Level stays 8, 0xAA appears as the last pop.
- Masked compare, priority:
  - Entries 0x100, 0x1FF, 0x200, 0x1AB, tag 0x100, mask 0xF00 → slots 0,1,3 hit, HitAge_oc=0.
  - After one read → HitAge_oc=0 (slot 1).
  - With RPtr wrapped to 6 and hits at slots 7 and 1 → HitAge_oc=1.
- Kill:
  - Kill tag 0x1FF in the same cycle as writing 0x1FF → the old entry's Vld is cleared and the new one stays valid.
  - Popping the old entry gives ReadValid_oc=0 and a Level decrement.
  - A later compare on 0x1FF hits only the new slot.
- CompareEn_i=0 with Kill_i=1 → Hit_oc=0, no Vld change.
- Reset mid-operation: assert snRst_i asynchronously with 5 entries → all outputs go to reset values without a clock edge; the first write afterwards lands at slot 0.
